mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/neander_mem_pkg.sv | 19 +
 rtl/mem_arbiter.sv | 144 ++++++++++++++
 tb/tb_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/neander_mem_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package neander_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_t;

    localparam logic        PORT_CPU  = 1'b0;
    localparam logic        PORT_HOST = 1'b1;
    localparam int unsigned NUM_PORTS = 2;

    // One-hot grant vector for a port index.
    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
        return port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single SPI memory controller.
// One transaction at a time: IDLE -> ISSUE (until s_ready) -> RESP (ready pulse).
module mem_arbiter
    import neander_mem_pkg::*;
#(
    parameter int unsigned ADDR_W     = 8,
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned FIXED_PRIO = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ready,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ready,
    output logic              s_req,
    output logic              s_we,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_wdata,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic              s_ready,
    output logic [1:0]        grant,
    output logic              busy
);

    arb_state_t        state, state_nx;
    logic              owner, owner_nx;
    logic              last_served, last_served_nx;
    logic              winner;
    logic              s_req_nx, s_we_nx;
    logic [ADDR_W-1:0] s_addr_nx;
    logic [DATA_W-1:0] s_wdata_nx, m0_rdata_nx, m1_rdata_nx;
    logic              m0_ready_nx, m1_ready_nx;
    logic [1:0]        grant_nx;
    logic              busy_nx;

    // Pick the port that would win if requests were sampled this cycle.
    always_comb begin
        winner = PORT_CPU;
        if (m0_req && m1_req) begin
            winner = (FIXED_PRIO != 0) ? PORT_HOST : ~last_served;
        end else if (m1_req) begin
            winner = PORT_HOST;
        end
    end

    // Next-state and next-output logic; every output is registered from these.
    always_comb begin
        state_nx       = state;
        owner_nx       = owner;
        last_served_nx = last_served;
        s_req_nx       = s_req;
        s_we_nx        = s_we;
        s_addr_nx      = s_addr;
        s_wdata_nx     = s_wdata;
        m0_rdata_nx    = m0_rdata;
        m1_rdata_nx    = m1_rdata;
        m0_ready_nx    = 1'b0;
        m1_ready_nx    = 1'b0;
        grant_nx       = grant;
        busy_nx        = busy;
        case (state)
            ST_IDLE: begin
                if (m0_req || m1_req) begin
                    owner_nx   = winner;
                    s_req_nx   = 1'b1;
                    s_we_nx    = (winner == PORT_HOST) ? m1_we    : m0_we;
                    s_addr_nx  = (winner == PORT_HOST) ? m1_addr  : m0_addr;
                    s_wdata_nx = (winner == PORT_HOST) ? m1_wdata : m0_wdata;
                    grant_nx   = port_onehot(winner);
                    busy_nx    = 1'b1;
                    state_nx   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (s_ready) begin
                    // Only reads refresh the requester's data register.
                    if (!s_we) begin
                        if (owner == PORT_HOST) m1_rdata_nx = s_rdata;
                        else                    m0_rdata_nx = s_rdata;
                    end
                    last_served_nx = owner;
                    s_req_nx       = 1'b0;
                    m0_ready_nx    = (owner == PORT_CPU);
                    m1_ready_nx    = (owner == PORT_HOST);
                    state_nx       = ST_RESP;
                end
            end
            ST_RESP: begin
                grant_nx = 2'b00;
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
            default: begin
                s_req_nx = 1'b0;
                grant_nx = 2'b00;
                busy_nx  = 1'b0;
                state_nx = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset also aborts any in-flight transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= PORT_CPU;
            last_served <= PORT_HOST;
            s_req       <= 1'b0;
            s_we        <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            grant       <= 2'b00;
            busy        <= 1'b0;
        end else begin
            state       <= state_nx;
            owner       <= owner_nx;
            last_served <= last_served_nx;
            s_req       <= s_req_nx;
            s_we        <= s_we_nx;
            s_addr      <= s_addr_nx;
            s_wdata     <= s_wdata_nx;
            m0_rdata    <= m0_rdata_nx;
            m1_rdata    <= m1_rdata_nx;
            m0_ready    <= m0_ready_nx;
            m1_ready    <= m1_ready_nx;
            grant       <= grant_nx;
            busy        <= busy_nx;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: round-robin and fixed-priority instances,
// each backed by a downstream memory model that answers in 3 cycles.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic       stray;

    // Round-robin instance signals.
    logic       m0_req, m0_we, m1_req, m1_we;
    logic [7:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [7:0] m0_rdata, m1_rdata;
    logic       m0_ready, m1_ready;
    logic       s_req, s_we, s_ready, s_ready_m;
    logic [7:0] s_addr, s_wdata, s_rdata;
    logic [1:0] grant;
    logic       busy;

    // Fixed-priority instance signals.
    logic       f_m0_req, f_m0_we, f_m1_req, f_m1_we;
    logic [7:0] f_m0_addr, f_m0_wdata, f_m1_addr, f_m1_wdata;
    logic [7:0] f_m0_rdata, f_m1_rdata;
    logic       f_m0_ready, f_m1_ready;
    logic       f_s_req, f_s_we, f_s_ready;
    logic [7:0] f_s_addr, f_s_wdata, f_s_rdata;
    logic [1:0] f_grant;
    logic       f_busy;

    logic [7:0] mem   [256];
    logic [7:0] f_mem [256];
    int         cnt, f_cnt;

    int vectors = 0;
    int errs    = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ready(m0_ready),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ready(m1_ready),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata),
        .s_rdata(s_rdata), .s_ready(s_ready),
        .grant(grant), .busy(busy)
    );

    mem_arbiter #(.ADDR_W(8), .DATA_W(8), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(reset),
        .m0_req(f_m0_req), .m0_we(f_m0_we), .m0_addr(f_m0_addr), .m0_wdata(f_m0_wdata),
        .m0_rdata(f_m0_rdata), .m0_ready(f_m0_ready),
        .m1_req(f_m1_req), .m1_we(f_m1_we), .m1_addr(f_m1_addr), .m1_wdata(f_m1_wdata),
        .m1_rdata(f_m1_rdata), .m1_ready(f_m1_ready),
        .s_req(f_s_req), .s_we(f_s_we), .s_addr(f_s_addr), .s_wdata(f_s_wdata),
        .s_rdata(f_s_rdata), .s_ready(f_s_ready),
        .grant(f_grant), .busy(f_busy)
    );

    // Downstream model for the round-robin instance: s_ready in the 3rd s_req cycle.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt         <= 0;
            s_ready_m   <= 1'b0;
            s_rdata     <= 8'h00;
            mem[8'h10]  <= 8'hA5;
            mem[8'h20]  <= 8'h3C;
            mem[8'h21]  <= 8'h00;
        end else if (s_req && !s_ready_m) begin
            if (cnt == 1) begin
                s_ready_m <= 1'b1;
                cnt       <= 0;
                if (s_we) mem[s_addr] <= s_wdata;
                else      s_rdata     <= mem[s_addr];
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            s_ready_m <= 1'b0;
        end
    end
    assign s_ready = s_ready_m | stray;

    // Downstream model for the fixed-priority instance.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            f_cnt        <= 0;
            f_s_ready    <= 1'b0;
            f_s_rdata    <= 8'h00;
            f_mem[8'h10] <= 8'hA5;
            f_mem[8'h20] <= 8'h3C;
            f_mem[8'h21] <= 8'h00;
        end else if (f_s_req && !f_s_ready) begin
            if (f_cnt == 1) begin
                f_s_ready <= 1'b1;
                f_cnt     <= 0;
                if (f_s_we) f_mem[f_s_addr] <= f_s_wdata;
                else        f_s_rdata       <= f_mem[f_s_addr];
            end else begin
                f_cnt <= f_cnt + 1;
            end
        end else begin
            f_s_ready <= 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        int   n;
        int   c0, c1;
        logic seen;
        logic [1:0] exp_g;

        reset = 1'b1; stray = 1'b0;
        m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        f_m0_req = 0; f_m0_we = 0; f_m0_addr = 0; f_m0_wdata = 0;
        f_m1_req = 0; f_m1_we = 0; f_m1_addr = 0; f_m1_wdata = 0;
        tick(); tick();

        // Reset values.
        chk("rst_s_req",  32'(s_req),   0);
        chk("rst_s_addr", 32'(s_addr),  0);
        chk("rst_s_wdata",32'(s_wdata), 0);
        chk("rst_s_we",   32'(s_we),    0);
        chk("rst_grant",  32'(grant),   0);
        chk("rst_busy",   32'(busy),    0);
        chk("rst_ready",  32'({m0_ready, m1_ready}), 0);
        chk("rst_rdata",  32'({m0_rdata, m1_rdata}), 0);
        reset = 1'b0;

        // Single port-0 read at 0x10, cycle by cycle.
        m0_req = 1; m0_we = 0; m0_addr = 8'h10;
        tick();
        chk("t1_c1_s_req", 32'(s_req),  1);
        chk("t1_c1_addr",  32'(s_addr), 32'h10);
        chk("t1_c1_we",    32'(s_we),   0);
        chk("t1_c1_grant", 32'(grant),  1);
        chk("t1_c1_busy",  32'(busy),   1);
        tick();
        chk("t1_c2_s_req", 32'(s_req),  1);
        tick();
        chk("t1_c3_s_req", 32'(s_req),  1);
        chk("t1_c3_ready", 32'(m0_ready), 0);
        tick();
        chk("t1_c4_s_req", 32'(s_req),    0);
        chk("t1_c4_ready", 32'(m0_ready), 1);
        chk("t1_c4_rdata", 32'(m0_rdata), 32'hA5);
        chk("t1_c4_m1rdy", 32'(m1_ready), 0);
        m0_req = 0;
        tick();
        chk("t1_c5_ready", 32'(m0_ready), 0);
        chk("t1_c5_busy",  32'(busy),     0);
        chk("t1_c5_grant", 32'(grant),    0);

        // s_ready while idle is ignored.
        stray = 1'b1;
        tick();
        stray = 1'b0;
        chk("stray_busy",  32'(busy), 0);
        tick();
        chk("stray_ready", 32'({m0_ready, m1_ready}), 0);
        chk("stray_rdata", 32'(m0_rdata), 32'hA5);

        // Simultaneous requests after reset: port 0 first, then port 1.
        pulse_reset();
        m0_req = 1; m0_we = 0; m0_addr = 8'h20;
        m1_req = 1; m1_we = 1; m1_addr = 8'h21; m1_wdata = 8'h5A;
        tick();
        chk("t2_grant0", 32'(grant),  1);
        chk("t2_addr0",  32'(s_addr), 32'h20);
        tick(); tick(); tick();
        chk("t2_m0_ready", 32'(m0_ready), 1);
        chk("t2_m0_rdata", 32'(m0_rdata), 32'h3C);
        m0_req = 0;
        tick();
        chk("t2_gap_grant", 32'(grant), 0);
        tick();
        chk("t2_grant1", 32'(grant),   2);
        chk("t2_we1",    32'(s_we),    1);
        chk("t2_addr1",  32'(s_addr),  32'h21);
        chk("t2_wdata1", 32'(s_wdata), 32'h5A);
        tick(); tick(); tick();
        chk("t2_m1_ready", 32'(m1_ready), 1);
        chk("t2_m0_quiet", 32'(m0_ready), 0);
        chk("t2_m1_rdata_kept", 32'(m1_rdata), 0);
        chk("t2_m0_rdata_kept", 32'(m0_rdata), 32'h3C);
        m1_req = 0; m1_we = 0;
        tick();
        chk("t2_mem_write", 32'(mem[8'h21]), 32'h5A);
        chk("t2_idle", 32'(busy), 0);

        // Both requesting continuously: grants alternate.
        pulse_reset();
        m0_req = 1; m0_we = 0; m0_addr = 8'h10;
        m1_req = 1; m1_we = 0; m1_addr = 8'h20;
        for (int k = 0; k < 6; k++) begin
            exp_g = (k % 2 == 0) ? 2'b01 : 2'b10;
            n = 0;
            while (grant == 2'b00 && n < 20) begin tick(); n++; end
            chk("rr_grant", 32'(grant), 32'(exp_g));
            n = 0;
            while (!(m0_ready || m1_ready) && n < 20) begin
                if (grant == 2'b11) chk("rr_grant_11", 32'(grant), 32'(exp_g));
                tick(); n++;
            end
            chk("rr_ready", 32'({m1_ready, m0_ready}), 32'(exp_g));
            if (exp_g == 2'b01) chk("rr_m0_rdata", 32'(m0_rdata), 32'hA5);
            else                chk("rr_m1_rdata", 32'(m1_rdata), 32'h3C);
            n = 0;
            while (busy && n < 20) begin tick(); n++; end
        end
        m0_req = 0; m1_req = 0;
        tick(); tick();
        chk("rr_end_idle", 32'(busy), 0);

        // Reset in the 2nd ISSUE cycle aborts the transaction.
        pulse_reset();
        m0_req = 1; m0_we = 0; m0_addr = 8'h10;
        tick();
        tick();
        chk("ab_s_req_pre", 32'(s_req), 1);
        reset = 1'b1;
        #1;
        chk("ab_s_req_async", 32'(s_req), 0);
        chk("ab_busy",        32'(busy),  0);
        chk("ab_grant",       32'(grant), 0);
        m0_req = 0;
        tick();
        reset = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (m0_ready || m1_ready || s_req) seen = 1'b1;
        end
        chk("ab_no_ready", 32'(seen), 0);
        m0_req = 1; m0_addr = 8'h20;
        n = 0;
        while (!m0_ready && n < 20) begin tick(); n++; end
        chk("ab_fresh_ready", 32'(m0_ready), 1);
        chk("ab_fresh_rdata", 32'(m0_rdata), 32'h3C);
        m0_req = 0;
        tick(); tick();

        // Port 1 drops req during ISSUE; transaction still completes.
        m1_req = 1; m1_we = 0; m1_addr = 8'h10;
        tick();
        chk("dr_grant", 32'(grant), 2);
        m1_req = 0;
        c0 = 0; c1 = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            if (m0_ready) c0++;
            if (m1_ready) c1++;
        end
        chk("dr_m1_pulses", 32'(c1), 1);
        chk("dr_m0_pulses", 32'(c0), 0);
        chk("dr_m1_rdata",  32'(m1_rdata), 32'hA5);
        chk("dr_busy",      32'(busy), 0);

        // Fixed priority: port 1 wins the tie.
        pulse_reset();
        f_m0_req = 1; f_m0_we = 0; f_m0_addr = 8'h20;
        f_m1_req = 1; f_m1_we = 1; f_m1_addr = 8'h21; f_m1_wdata = 8'h5A;
        tick();
        chk("fp_grant1", 32'(f_grant), 2);
        chk("fp_we1",    32'(f_s_we),  1);
        n = 0;
        while (!f_m1_ready && n < 20) begin tick(); n++; end
        chk("fp_m1_ready", 32'(f_m1_ready), 1);
        f_m1_req = 0;
        n = 0;
        while (f_grant == 2'b00 || f_grant == 2'b10) begin
            if (n >= 20) break;
            tick(); n++;
        end
        chk("fp_grant0", 32'(f_grant), 1);
        n = 0;
        while (!f_m0_ready && n < 20) begin tick(); n++; end
        chk("fp_m0_ready", 32'(f_m0_ready), 1);
        chk("fp_m0_rdata", 32'(f_m0_rdata), 32'h3C);
        f_m0_req = 0;
        tick();
        chk("fp_mem_write", 32'(f_mem[8'h21]), 32'h5A);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end

endmodule
